// File: rtl/serial_or_pkg.sv
// Shared types and defaults for the serial OR-reduction block.
package serial_or_pkg;

    localparam int FRAME_LEN_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/frame_bit_counter.sv
// Bit index within a frame; wraps to 0 after the last bit, flags the last index.
module frame_bit_counter
    import serial_or_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         clr,
    output logic [$clog2(FRAME_LEN)-1:0] idx,
    output logic                         last
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/or_mux2.sv
// Two-input OR gate built from a 2:1 mux: y = a ? 1 : b.
module or_mux2 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ? 1'b1 : b;

endmodule

// File: rtl/serial_or_reduce.sv
// Accumulates a serial frame, then holds OR / popcount / first-one index until taken.
module serial_or_reduce
    import serial_or_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_bit,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_or,
    output logic [$clog2(FRAME_LEN+1)-1:0] out_ones,
    output logic [$clog2(FRAME_LEN)-1:0]   out_first
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] ONES_MAX = CNT_W'(FRAME_LEN);

    state_e             state_q, state_d;
    logic               live_q;
    logic               in_xfer, out_xfer;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic               or_acc, or_next;
    logic [CNT_W-1:0]   ones_acc;
    logic [IDX_W-1:0]   first_idx;

    // live_q keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    assign in_ready  = live_q && (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    frame_bit_counter #(.FRAME_LEN(FRAME_LEN)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_xfer),
        .clr   (out_xfer),
        .idx   (idx),
        .last  (last)
    );

    or_mux2 u_or (
        .a (or_acc),
        .b (in_bit),
        .y (or_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_xfer)         state_d = ACCUM;
            ACCUM:   if (in_xfer && last) state_d = HOLD;
            HOLD:    if (out_xfer)        state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_acc    <= 1'b0;
            ones_acc  <= '0;
            first_idx <= '0;
        end else if (out_xfer) begin
            or_acc    <= 1'b0;
            ones_acc  <= '0;
            first_idx <= '0;
        end else if (in_xfer) begin
            or_acc <= or_next;
            if (in_bit && (ones_acc != ONES_MAX)) ones_acc <= ones_acc + 1'b1;
            // or_acc still low means this is the frame's first 1
            if (in_bit && !or_acc) first_idx <= idx;
        end
    end

    assign out_or    = or_acc;
    assign out_ones  = ones_acc;
    assign out_first = first_idx;

endmodule

// File: tb/tb_serial_or_reduce.sv
// Randomized and directed bench for serial_or_reduce against a frame-level model.
module tb_serial_or_reduce;

    typedef struct packed {
        logic       o;
        logic [3:0] ones;
        logic [2:0] first;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_bit = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_or;
    logic [3:0] out_ones;
    logic [2:0] out_first;

    int   tests = 0;
    int   fails = 0;
    int   vcycles = 0;
    bit   rand_ready = 1'b0;
    res_t got_q[$];
    res_t exp_q[$];

    always #5 clk = ~clk;

    serial_or_reduce #(.FRAME_LEN(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_or    (out_or),
        .out_ones  (out_ones),
        .out_first (out_first)
    );

    // Samples just after the inactive edge; inputs there are settled for the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (out_valid === 1'b1) vcycles++;
        if (out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back('{o: out_or, ones: out_ones, first: out_first});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input logic [7:0] bits);
        res_t r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) begin
                r.o     = 1'b1;
                r.ones  = r.ones + 4'd1;
                r.first = 3'(i);
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Entered and left at a falling edge; returns once the bit has been taken.
    task automatic send_bit(input logic b);
        int n = 0;
        in_valid = 1'b1;
        in_bit   = b;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bits, input int gap);
        exp_q.push_back(model(bits));
        for (int i = 0; i < 8; i++) begin
            send_bit(bits[i]);
            if (i < 7) repeat (gap) tick();
        end
    endtask

    task automatic wait_results(input string name);
        int   n = 0;
        res_t g, e;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        while (got_q.size() < exp_q.size() && n < 300) begin
            tick();
            n++;
        end
        repeat (3) tick();
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s result_count: got %0d results, required %0d", name, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL %s frame: got or=%b ones=%0d first=%0d, required or=%b ones=%0d first=%0d",
                         name, g.o, g.ones, g.first, e.o, e.ones, e.first);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({out_valid, out_or, out_ones, out_first, in_ready} !== 10'b0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b or=%b ones=%0d first=%0d in_ready=%b, required all 0",
                     out_valid, out_or, out_ones, out_first, in_ready);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_ready: got in_ready=%b before first edge, required 0", in_ready);
        end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_edge_ready: got in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_zero_frame();
        int v0;
        out_ready = 1'b1;
        v0 = vcycles;
        send_frame(8'h00, 0);
        wait_results("zero_frame");
        tests++;
        if (vcycles - v0 != 1) begin
            fails++;
            $display("FAIL zero_frame_valid_cycles: got %0d, required 1", vcycles - v0);
        end
    endtask

    task automatic test_sparse();
        out_ready = 1'b1;
        send_frame(8'b0010_0100, 0);
        wait_results("sparse");
    endtask

    task automatic test_gapped_ones();
        out_ready = 1'b1;
        exp_q.push_back(model(8'hFF));
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1);
            tick();
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL gapped_early_valid: got out_valid=%b before 8th bit, required 0", out_valid);
        end
        send_bit(1'b1);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL gapped_latency: got out_valid=%b one cycle after 8th bit, required 1", out_valid);
        end
        wait_results("gapped_ones");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_frame(8'h80, 0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({out_valid, out_or, out_ones, out_first, in_ready} !== {1'b1, 1'b1, 4'd1, 3'd7, 1'b0}) begin
                fails++;
                $display("FAIL hold_stable: cycle %0d got valid=%b or=%b ones=%0d first=%0d in_ready=%b, required 1 1 1 7 0",
                         k, out_valid, out_or, out_ones, out_first, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        send_frame(8'h01, 0);
        wait_results("backpressure");
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_or, out_ones, out_first, in_ready} !== 10'b0) begin
            fails++;
            $display("FAIL midframe_reset_outputs: got valid=%b or=%b ones=%0d first=%0d in_ready=%b, required all 0",
                     out_valid, out_or, out_ones, out_first, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h01, 0);
        wait_results("reset_midframe");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_frame(8'h00, 0);
        send_frame(8'hFF, 0);
        wait_results("back_to_back");
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int f = 0; f < 16; f++)
            send_frame(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        wait_results("random");
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_sparse();
        test_gapped_ones();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_or_reduce.md
SERIAL_OR_REDUCE -- requirements
Module: serial_or_reduce

Interface
REQ-001 Parameter FRAME_LEN, default 8, bits per frame, legal range 2..255.
REQ-002 Derived constants: CNT_W = $clog2(FRAME_LEN+1) and IDX_W = $clog2(FRAME_LEN); neither is overridable.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: in_bit is valid this cycle.
REQ-006 Port in_ready, output, 1 bit: block accepts a bit this cycle.
REQ-007 Port in_bit, input, 1 bit: serial data bit; bit 0 of a frame arrives first.
REQ-008 Port out_valid, output, 1 bit: frame result is available.
REQ-009 Port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-010 Port out_or, output, 1 bit: OR of all FRAME_LEN bits of the frame.
REQ-011 Port out_ones, output, CNT_W bits: count of 1 bits in the frame.
REQ-012 Port out_first, output, IDX_W bits: index of the lowest-numbered 1 bit; 0 when out_or=0.

Function
REQ-013 An input transfer occurs when in_valid and in_ready are both high in the same cycle; any other cycle leaves the accumulators unchanged.
REQ-014 An output transfer occurs when out_valid and out_ready are both high in the same cycle.
REQ-015 States: IDLE (no bits held), ACCUM (1..FRAME_LEN-1 bits held), HOLD (result presented).
REQ-016 Transitions:
- IDLE to ACCUM on an input transfer.
- ACCUM to HOLD on the input transfer of bit index FRAME_LEN-1.
- HOLD to IDLE on an output transfer.
- Every other condition holds the current state.
REQ-017 in_ready = 1 in IDLE and ACCUM, and 0 in HOLD; there is no input-to-output bypass and no acceptance in the same cycle as an output transfer.
REQ-018 out_valid = 1 exactly in HOLD; it is registered, not combinational from any input.
REQ-019 Latency: out_valid rises the cycle after the transfer of the last bit of a frame.
REQ-020 Per accepted bit:
- or_acc |= in_bit.
- ones_acc increments when in_bit=1; it saturates only at FRAME_LEN, which it cannot exceed.
- first_idx latches the bit index on the first accepted 1 of the frame and ignores later 1s.
REQ-021 The bit index counter runs 0..FRAME_LEN-1 and wraps to 0 on entry to HOLD.
REQ-022 While out_valid=1 and out_ready=0, out_or, out_ones and out_first stay stable for any number of cycles.
REQ-023 On an output transfer, all accumulators clear so the next frame starts from zero.
REQ-024 in_valid may drop mid-frame for any number of cycles; the partial frame is retained and no timeout applies.
REQ-025 out_ready asserted outside HOLD has no effect.

Reset
REQ-026 rst_n low asynchronously forces state IDLE and clears the index counter, or_acc, ones_acc and first_idx to 0.
REQ-027 During reset, out_valid=0, out_or=0, out_ones=0, out_first=0, and in_ready=0.
REQ-028 in_ready goes high the first clock edge after rst_n deasserts.
REQ-029 Reset mid-frame or in HOLD discards the partial frame or pending result; no output transfer occurs for it.

Structure
REQ-030 Shared package serial_or_pkg holds:
- the state enum type (IDLE, ACCUM, HOLD), 2 bits;
- the default FRAME_LEN constant.
REQ-031 The index counter with its wrap and last-bit flag is a sub-module, frame_bit_counter (params FRAME_LEN; ports clk, rst_n, inc, clr, idx, last).
REQ-032 The OR accumulation is built from the existing mux-based OR gate instance; no behavioural | is used for or_acc.

Verification (FRAME_LEN=8)
REQ-033 Frame 00000000, with out_ready held high: out_or=0, out_ones=0, out_first=0, out_valid high for exactly 1 cycle.
REQ-034 Frame bits 0..7 = 0,0,1,0,0,1,0,0: out_or=1, out_ones=2, out_first=2.
REQ-035 Frame 11111111, with in_valid gapped every other cycle: out_or=1, out_ones=8, out_first=0; out_valid rises 1 cycle after the 8th transfer.
REQ-036 Frame with only bit 7 = 1, with out_ready held low 3 cycles: outputs stable at out_or=1, out_ones=1, out_first=7; in_ready=0 throughout; the next frame is accepted only after the transfer.
REQ-037 rst_n pulsed low after 5 accepted 1s, then a frame 00000001 is sent: out_ones=1, out_first=0 (no carry-over from the aborted frame).
REQ-038 Two back-to-back frames (all 0s, then all 1s): exactly 2 results, in order (0/0/0, then 1/8/0).
